universal_shift_register: RTL and testbench

UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

---
 rtl/universal_shift_register.sv | 88 ++++++++
 tb/tb_universal_shift_register.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// N-bit universal shift register: hold, shift left/right, parallel load, rotate.
// Counts serial shifts and pulses frame_done once every N shifts.
module universal_shift_register #(
  parameter int unsigned     N           = 4,
  parameter logic [N-1:0]    RESET_VALUE = '0,
  localparam int unsigned    CW          = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic [2:0]    mode,
  input  logic          data_in,
  input  logic [N-1:0]  d,
  output logic [N-1:0]  q,
  output logic          serial_out,
  output logic [CW-1:0] count,
  output logic          frame_done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;

  localparam logic [CW-1:0] LAST_SHIFT = CW'(N - 1);

  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          shift_c;

  // Next-state: data path per mode, plus frame counting for serial shifts only
  always_comb begin
    q_d     = q_q;
    count_d = count_q;
    done_d  = 1'b0;
    shift_c = 1'b0;
    if (ena) begin
      case (mode)
        MODE_SHL: begin
          q_d     = {q_q[N-2:0], data_in};
          shift_c = 1'b1;
        end
        MODE_SHR: begin
          q_d     = {data_in, q_q[N-1:1]};
          shift_c = 1'b1;
        end
        MODE_LOAD: begin
          q_d     = d;
          count_d = '0;
        end
        MODE_ROTL: q_d = {q_q[N-2:0], q_q[N-1]};
        MODE_ROTR: q_d = {q_q[0], q_q[N-1:1]};
        MODE_HOLD: q_d = q_q;
        default:   q_d = q_q;
      endcase
      if (shift_c) begin
        if (count_q == LAST_SHIFT) begin
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= RESET_VALUE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign q          = q_q;
  assign count      = count_q;
  assign frame_done = done_q;
  // Serial output follows the direction data leaves the register
  assign serial_out = ((mode == MODE_SHR) || (mode == MODE_ROTR)) ? q_q[0] : q_q[N-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Bench for universal_shift_register (N=4): directed literal scenarios, then
// randomized traffic checked every cycle against an arithmetic model.
module tb_universal_shift_register;

  localparam int unsigned N    = 4;
  localparam int unsigned CW   = $clog2(N + 1);
  localparam int          MASK = (1 << N) - 1;

  logic          clk;
  logic          t_rst, t_ena, t_din;
  logic [2:0]    t_mode;
  logic [N-1:0]  t_d;
  logic [N-1:0]  q;
  logic          serial_out;
  logic [CW-1:0] count;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  int m_q      = 0;
  int m_shifts = 0;
  int m_fd     = 0;
  bit m_valid  = 1'b0;

  universal_shift_register #(.N(N), .RESET_VALUE('0)) dut (
    .clk        (clk),
    .rst        (t_rst),
    .ena        (t_ena),
    .mode       (t_mode),
    .data_in    (t_din),
    .d          (t_d),
    .q          (q),
    .serial_out (serial_out),
    .count      (count),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shifts counted as a running total since load/reset;
  // count is that total modulo N, a frame completes each multiple of N.
  always @(posedge clk) begin
    bit shifted;
    int exp_so;
    shifted = 1'b0;
    if (t_rst) begin
      m_q = 0; m_shifts = 0; m_fd = 0; m_valid = 1'b1;
    end else if (t_ena) begin
      case (t_mode)
        3'd1: begin m_q = ((m_q * 2) + int'(t_din)) & MASK; shifted = 1'b1; end
        3'd2: begin m_q = (m_q / 2) + (int'(t_din) << (N - 1)); shifted = 1'b1; end
        3'd3: begin m_q = int'(t_d); m_shifts = 0; end
        3'd4: m_q = ((m_q * 2) & MASK) + (m_q / (1 << (N - 1)));
        3'd5: m_q = (m_q / 2) + ((m_q % 2) << (N - 1));
        default: ;
      endcase
      if (shifted) m_shifts++;
      m_fd = (shifted && (m_shifts % N == 0)) ? 1 : 0;
    end else begin
      m_fd = 0;
    end
    #2;
    if (m_valid) begin
      exp_so = ((t_mode == 3'd2) || (t_mode == 3'd5)) ? (m_q % 2) : (m_q >> (N - 1)) & 1;
      chk("model_q", int'(q), m_q);
      chk("model_count", int'(count), m_shifts % N);
      chk("model_frame_done", int'(frame_done), m_fd);
      chk("model_serial_out", int'(serial_out), exp_so);
    end
  end

  // One clock: drive at negedge, return 1 time unit after the rising edge
  task automatic cyc(input logic r, input logic e, input logic [2:0] m,
                     input logic di, input logic [N-1:0] dd);
    @(negedge clk);
    t_rst = r; t_ena = e; t_mode = m; t_din = di; t_d = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int last_pulse;
    logic [3:0] bits;
    t_rst = 1'b0; t_ena = 1'b0; t_mode = 3'd0; t_din = 1'b0; t_d = '0;

    // Reset state
    cyc(1, 0, 3'd0, 0, 4'h0);
    chk("rst_q", int'(q), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_fd", int'(frame_done), 0);
    chk("rst_so", int'(serial_out), 0);

    // SHL 1,0,1,0 completes a frame
    bits = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      cyc(0, 1, 3'd1, bits[i], 4'h0);
      if (i == 1) chk("shl3_count", int'(count), 3);
      if (i == 1) chk("shl3_fd", int'(frame_done), 0);
    end
    chk("shl_q", int'(q), 4'b1010);
    chk("shl_fd", int'(frame_done), 1);
    chk("shl_count", int'(count), 0);
    cyc(0, 1, 3'd0, 0, 4'h0);
    chk("hold_fd", int'(frame_done), 0);

    // LOAD then rotates
    cyc(0, 1, 3'd3, 0, 4'b1100);
    chk("load_q", int'(q), 4'b1100);
    cyc(0, 1, 3'd4, 0, 4'h0);
    chk("rotl_q", int'(q), 4'b1001);
    cyc(0, 1, 3'd5, 0, 4'h0);
    cyc(0, 1, 3'd5, 0, 4'h0);
    chk("rotr_q", int'(q), 4'b0110);
    chk("rot_count", int'(count), 0);
    chk("rot_fd", int'(frame_done), 0);

    // SHR then disabled edges hold everything
    cyc(1, 1, 3'd0, 0, 4'h0);
    cyc(0, 1, 3'd2, 1, 4'h0);
    cyc(0, 1, 3'd2, 1, 4'h0);
    chk("shr_q", int'(q), 4'b1100);
    chk("shr_count", int'(count), 2);
    chk("shr_so", int'(serial_out), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 3'd1, 1, 4'hF);
    chk("ena0_q", int'(q), 4'b1100);
    chk("ena0_count", int'(count), 2);
    chk("ena0_fd", int'(frame_done), 0);

    // LOAD at count N-1 clears without a frame
    cyc(1, 1, 3'd0, 0, 4'h0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 3'd1, 0, 4'h0);
    chk("pre_load_count", int'(count), 3);
    cyc(0, 1, 3'd3, 0, 4'b0101);
    chk("load3_q", int'(q), 4'b0101);
    chk("load3_count", int'(count), 0);
    chk("load3_fd", int'(frame_done), 0);
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 3'd1, 0, 4'h0);
      if (frame_done) pulses++;
      if (i == 4) chk("load3_frame_at4", int'(frame_done), 1);
    end
    chk("load3_pulses", pulses, 1);

    // Mid-frame reset discards partial frame; back-to-back frames
    cyc(1, 1, 3'd0, 0, 4'h0);
    cyc(0, 1, 3'd1, 1, 4'h0);
    cyc(0, 1, 3'd1, 1, 4'h0);
    cyc(1, 1, 3'd1, 1, 4'h0);
    chk("midrst_q", int'(q), 0);
    chk("midrst_count", int'(count), 0);
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 3'd1, 1, 4'h0);
      if (frame_done) pulses++;
    end
    chk("fresh_frame_at4", int'(frame_done), 1);
    chk("fresh_pulses", pulses, 1);
    pulses = 0; last_pulse = 0;
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, (i % 2 == 0) ? 3'd2 : 3'd1, 0, 4'h0);
      if (frame_done) begin
        pulses++;
        if (pulses == 2) chk("b2b_spacing", i - last_pulse, 4);
        last_pulse = i;
      end
    end
    chk("b2b_pulses", pulses, 2);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] m;
      m = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) m = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd2;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), m,
          1'($urandom), 4'($urandom));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
